// File: rtl/mac_pkg.sv
// Shared parameters, lane-slice helper and window tag payload for the multi-lane MAC core.
package mac_pkg;

  localparam int unsigned MAC_LANES   = 5;
  localparam int unsigned MAC_DW      = 16;
  localparam int unsigned MAC_CW      = 36;
  localparam int unsigned MAC_ACC_LEN = 4;

  // LSB offset of lane `lane` in a bus of `w`-bit lanes (lane 0 in the LSBs)
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  typedef struct packed {
    logic first;
    logic last;
  } win_tag_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: product register, window accumulator and result register.
module mac_lane #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          first,
  input  logic          last,
  input  logic          in_vld,
  output logic [CW-1:0] c,
  output logic          vld
);

  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] c_q, c_d;
  logic          vld_q, vld_d;

  // Idle cycles register a zero product, so the accumulator simply holds between samples
  always_comb begin
    p_d   = in_vld ? (PW'(a) * PW'(b)) : '0;
    acc_d = first ? CW'(p_q) : (acc_q + CW'(p_q));
    c_d   = last ? acc_q : c_q;
    vld_d = last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      acc_q <= '0;
      c_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      acc_q <= acc_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign c   = c_q;
  assign vld = vld_q;

endmodule

// File: rtl/multi_mac_base.sv
// LANES-wide lock-step MAC core: window counter and shared first/last tag pipeline feeding the lanes.
module multi_mac_base
  import mac_pkg::*;
#(
  parameter int unsigned LANES   = MAC_LANES,
  parameter int unsigned DW      = MAC_DW,
  parameter int unsigned CW      = MAC_CW,
  parameter int unsigned ACC_LEN = MAC_ACC_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sof,
  input  logic [LANES*DW-1:0] A,
  input  logic [DW-1:0]       B,
  output logic [LANES*CW-1:0] C,
  output logic [LANES-1:0]    valid
);

  localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos_c;
  logic             sof_q;
  win_tag_t         s1_q, s1_d;
  logic             last2_q;

  // A sof rising edge always starts a window at position 0
  always_comb begin
    pos_c      = sof_q ? cnt_q : '0;
    s1_d.first = sof & (pos_c == '0);
    s1_d.last  = sof & (pos_c == CNT_W'(ACC_LEN - 1));
    if (!sof || s1_d.last) begin
      cnt_d = '0;
    end else begin
      cnt_d = pos_c + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sof_q   <= 1'b0;
      s1_q    <= '0;
      last2_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sof_q   <= sof;
      s1_q    <= s1_d;
      last2_q <= s1_q.last;
    end
  end

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    mac_lane #(
      .DW(DW),
      .CW(CW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (A[lane_lo(i, DW) +: DW]),
      .b     (B),
      .first (s1_q.first),
      .last  (last2_q),
      .in_vld(sof),
      .c     (C[lane_lo(i, CW) +: CW]),
      .vld   (valid[i])
    );
  end

endmodule

// File: tb/tb_multi_mac_base.sv
// Self-checking bench for multi_mac_base: ACC_LEN=4 and ACC_LEN=16 instances against a sample-level window model.
module tb_multi_mac_base;

  localparam int unsigned L   = 5;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 36;
  localparam int unsigned CBW = L * CW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sof;
  logic [L*DW-1:0] A;
  logic [DW-1:0]   B;
  logic [CBW-1:0]  C4, C16;
  logic [L-1:0]    v4, v16;

  int total = 0;
  int bad   = 0;
  int pulses4 = 0;

  // Model state per instance: window length, samples seen, running sums, 2-edge output delay line
  int unsigned       len [2] = '{4, 16};
  int unsigned       m_cnt [2];
  longint unsigned   m_sum [2][L];
  longint unsigned   p0c [2][L], p1c [2][L], ec [2][L];
  bit                p0v [2], p1v [2], ev [2];

  always #5 clk = ~clk;

  multi_mac_base u_dut4 (
    .clk(clk), .rst_n(rst_n), .sof(sof), .A(A), .B(B), .C(C4), .valid(v4)
  );

  multi_mac_base #(.ACC_LEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sof(sof), .A(A), .B(B), .C(C16), .valid(v16)
  );

  task automatic chk(input string tag, input logic [CBW-1:0] obs, input logic [CBW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] rand_a();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[L*DW-1:0];
  endfunction

  function automatic logic [CBW-1:0] exp_c(input int d);
    logic [CBW-1:0] r;
    for (int l = 0; l < int'(L); l++) r[l*CW +: CW] = CW'(ec[d][l]);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; p0v[d] = 0; p1v[d] = 0; ev[d] = 0;
      for (int l = 0; l < int'(L); l++) begin
        m_sum[d][l] = 0; p0c[d][l] = 0; p1c[d][l] = 0; ec[d][l] = 0;
      end
    end
  endtask

  // One clock edge of behaviour: completed windows appear on the outputs two edges later
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      ev[d] = p1v[d];
      for (int l = 0; l < int'(L); l++) if (p1v[d]) ec[d][l] = p1c[d][l];
      p1v[d] = p0v[d];
      for (int l = 0; l < int'(L); l++) p1c[d][l] = p0c[d][l];
      p0v[d] = 0;
      if (sof) begin
        if (m_cnt[d] == 0) for (int l = 0; l < int'(L); l++) m_sum[d][l] = 0;
        for (int l = 0; l < int'(L); l++)
          m_sum[d][l] += longint'(A[l*DW +: DW]) * longint'(B);
        m_cnt[d]++;
        if (m_cnt[d] == len[d]) begin
          p0v[d] = 1;
          for (int l = 0; l < int'(L); l++) p0c[d][l] = m_sum[d][l] % (64'd1 << CW);
          m_cnt[d] = 0;
        end
      end else begin
        m_cnt[d] = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_c4"},  C4,  exp_c(0));
    chk({tag, "_v4"},  CBW'(v4),  CBW'({L{ev[0]}}));
    chk({tag, "_c16"}, C16, exp_c(1));
    chk({tag, "_v16"}, CBW'(v16), CBW'({L{ev[1]}}));
  endtask

  task automatic step(input string tag, input logic s, input logic [L*DW-1:0] a, input logic [DW-1:0] b);
    sof = s; A = a; B = b;
    @(posedge clk);
    model_edge();
    #1;
    if (v4 != '0) pulses4++;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, rand_a(), DW'($urandom()));
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [L*DW-1:0] a;
    int unsigned     k;
    rst_n = 1'b0;
    model_reset();

    // 1: reset held with random inputs, then idle after release
    for (int i = 0; i < 4; i++) begin
      sof = 1'($urandom()); A = rand_a(); B = DW'($urandom());
      @(posedge clk);
      #1;
      check_outputs("t1_rst");
    end
    #2;
    rst_n = 1'b1;
    idle("t1_idle", 3);

    // 2: basic window
    for (int i = 0; i < 4; i++) step("t2", 1'b1, 80'h00020007000900030005, 16'd4);
    idle("t2_out", 2);
    chk("t2_valid", CBW'(v4), CBW'(5'h1F));
    chk("t2_lanes", C4, {36'h20, 36'h70, 36'h90, 36'h30, 36'h50});
    idle("t2_hold", 3);
    chk("t2_hold_c", C4, {36'h20, 36'h70, 36'h90, 36'h30, 36'h50});

    // 3: continuous sof for 10 samples, two pulses, tail discarded
    pulses4 = 0;
    for (int i = 0; i < 10; i++) step("t3", 1'b1, 80'h00020007000900030005, 16'd4);
    idle("t3_tail", 6);
    chk("t3_pulses", CBW'(pulses4), CBW'(2));
    chk("t3_lanes", C4, {36'h20, 36'h70, 36'h90, 36'h30, 36'h50});

    // 4: maximum operands over a 16-sample window
    for (int i = 0; i < 16; i++) step("t4", 1'b1, {L{16'hFFFF}}, 16'hFFFF);
    idle("t4_out", 2);
    chk("t4_valid16", CBW'(v16), CBW'(5'h1F));
    chk("t4_lanes16", C16, {L{36'hFFFE00010}});
    idle("t4_gap", 2);

    // 5: varying data; window start loads rather than adding to the previous result
    for (k = 1; k <= 4; k++) begin
      a = rand_a();
      a[DW-1:0] = DW'(k);
      step("t5", 1'b1, a, DW'(k + 4));
    end
    idle("t5_out", 2);
    chk("t5_lane0", CBW'(C4[CW-1:0]), CBW'(70));
    idle("t5_gap", 2);

    // 6: aborted partial window, then a clean one
    pulses4 = 0;
    step("t6_part", 1'b1, rand_a(), DW'($urandom()));
    step("t6_part", 1'b1, rand_a(), DW'($urandom()));
    idle("t6_drop", 1);
    for (int i = 0; i < 4; i++) step("t6", 1'b1, {L{16'd1}}, 16'd1);
    idle("t6_out", 4);
    chk("t6_pulses", CBW'(pulses4), CBW'(1));
    chk("t6_lanes", C4, {L{36'd4}});

    // Random traffic with mixed sof patterns
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 8) step("rnd", 1'b1, rand_a(), DW'($urandom()));
      else                       step("rnd", 1'b0, rand_a(), DW'($urandom()));
    end
    idle("rnd_tail", 4);

    // Reset in the middle of a window: nothing emitted, results cleared
    pulses4 = 0;
    step("t6r", 1'b1, rand_a(), DW'($urandom()));
    step("t6r", 1'b1, rand_a(), DW'($urandom()));
    async_reset("t6r");
    idle("t6r_after", 4);
    chk("t6r_c", C4, '0);
    chk("t6r_pulses", CBW'(pulses4), CBW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
